// File: rtl/bcd_cnt_pkg.sv
// -----------------------------------------------------------------------------
// bcd_cnt_pkg
// Shared definitions for the multi-digit BCD up/down counter:
//   BCD_MAX / BCD_MIN  : decade limits (9 and 0)
//   bcd_digit_t        : one packed BCD decade
//   bcd_valid()        : true when a nibble holds a legal BCD code (0..9)
// -----------------------------------------------------------------------------
package bcd_cnt_pkg;

    localparam logic [3:0] BCD_MAX = 4'd9;
    localparam logic [3:0] BCD_MIN = 4'd0;

    typedef logic [3:0] bcd_digit_t;

    function automatic logic bcd_valid(input bcd_digit_t digit);
        return (digit <= BCD_MAX);
    endfunction

endpackage

// File: rtl/bcd_digit.sv
// -----------------------------------------------------------------------------
// bcd_digit
// One BCD decade register with load, increment and decrement.
// Ports:
//   CLK, RST_N       : clock, asynchronous active-low reset
//   step_up, step_dn : advance this decade by +1 / -1 (9->0 / 0->9 rollover)
//   load, load_val   : synchronous preset; has priority over stepping
//   digit            : current decade value (registered)
//   at_max, at_min   : decade currently holds 9 / 0
// -----------------------------------------------------------------------------
module bcd_digit
    import bcd_cnt_pkg::*;
(
    input  logic       CLK,
    input  logic       RST_N,
    input  logic       step_up,
    input  logic       step_dn,
    input  logic       load,
    input  bcd_digit_t load_val,
    output bcd_digit_t digit,
    output logic       at_max,
    output logic       at_min
);

    bcd_digit_t digit_r;
    bcd_digit_t digit_nxt_s;

    // Next decade value: load, then up step, then down step, else hold.
    always_comb begin
        digit_nxt_s = digit_r;
        if (load) begin
            digit_nxt_s = load_val;
        end else if (step_up) begin
            if (digit_r == BCD_MAX) begin
                digit_nxt_s = BCD_MIN;
            end else begin
                digit_nxt_s = digit_r + 4'd1;
            end
        end else if (step_dn) begin
            if (digit_r == BCD_MIN) begin
                digit_nxt_s = BCD_MAX;
            end else begin
                digit_nxt_s = digit_r - 4'd1;
            end
        end else begin
            digit_nxt_s = digit_r;
        end
    end

    // Decade state register.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            digit_r <= BCD_MIN;
        end else begin
            digit_r <= digit_nxt_s;
        end
    end

    assign digit  = digit_r;
    assign at_max = (digit_r == BCD_MAX);
    assign at_min = (digit_r == BCD_MIN);

endmodule

// File: rtl/bcd_updown_counter.sv
// -----------------------------------------------------------------------------
// bcd_updown_counter
// DIGITS-decade packed BCD up/down pulse counter with validated preset load.
// Ports:
//   CLK   : clock (rising edge)
//   RST_N : asynchronous active-low reset
//   EN    : count enable, one step per cycle
//   DIR   : 1 = count up, 0 = count down (used only while EN is high)
//   LOAD  : synchronous preset strobe (wins over EN)
//   DIN   : preset value, packed BCD, digit 0 in [3:0]
//   BCD   : current count, packed BCD, registered
//   WRAP  : one-cycle pulse after a step across the 0 / all-nines boundary
//   ZERO  : count is all zeros
//   ERR   : one-cycle pulse after a LOAD rejected for a non-BCD nibble
// Build option:
//   BCD_CNT_SAT_EN : when defined, the count saturates at all nines / zero
//                    and WRAP flags each blocked step instead of a rollover.
// -----------------------------------------------------------------------------
module bcd_updown_counter
    import bcd_cnt_pkg::*;
#(
    parameter int DIGITS = 4
) (
    input  logic                CLK,
    input  logic                RST_N,
    input  logic                EN,
    input  logic                DIR,
    input  logic                LOAD,
    input  logic [4*DIGITS-1:0] DIN,
    output logic [4*DIGITS-1:0] BCD,
    output logic                WRAP,
    output logic                ZERO,
    output logic                ERR
);

    logic [DIGITS-1:0] at_max_s;
    logic [DIGITS-1:0] at_min_s;
    logic [DIGITS-1:0] nib_ok_s;
    logic [DIGITS-1:0] step_up_s;
    logic [DIGITS-1:0] step_dn_s;
    logic [DIGITS:0]   below_max_s;
    logic [DIGITS:0]   below_min_s;
    logic              load_ok_s;
    logic              up_s;
    logic              dn_s;
    logic              edge_hit_s;
    logic              block_s;
    logic              wrap_r;
    logic              err_r;

    // Whole-word validity: a LOAD is accepted only if every nibble is BCD.
    assign load_ok_s = LOAD & (&nib_ok_s);
    assign up_s      = EN & ~LOAD & DIR;
    assign dn_s      = EN & ~LOAD & ~DIR;

    // Carry/borrow enables: decade i moves when all lower decades are at 9 (up)
    // or at 0 (down). below_*[DIGITS] is the full-word boundary detect.
    always_comb begin
        below_max_s    = {(DIGITS+1){1'b0}};
        below_min_s    = {(DIGITS+1){1'b0}};
        below_max_s[0] = 1'b1;
        below_min_s[0] = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            below_max_s[i+1] = below_max_s[i] & at_max_s[i];
            below_min_s[i+1] = below_min_s[i] & at_min_s[i];
        end
    end

    assign edge_hit_s = (up_s & below_max_s[DIGITS]) | (dn_s & below_min_s[DIGITS]);

`ifdef BCD_CNT_SAT_EN
    assign block_s = edge_hit_s;
`else
    assign block_s = 1'b0;
`endif

    // Per-decade step strobes; a saturated boundary step is suppressed entirely.
    always_comb begin
        step_up_s = {DIGITS{1'b0}};
        step_dn_s = {DIGITS{1'b0}};
        for (int i = 0; i < DIGITS; i++) begin
            step_up_s[i] = up_s & ~block_s & below_max_s[i];
            step_dn_s[i] = dn_s & ~block_s & below_min_s[i];
        end
    end

    for (genvar g = 0; g < DIGITS; g++) begin : g_digit
        assign nib_ok_s[g] = bcd_valid(DIN[4*g +: 4]);

        bcd_digit u_digit (
            .CLK      (CLK),
            .RST_N    (RST_N),
            .step_up  (step_up_s[g]),
            .step_dn  (step_dn_s[g]),
            .load     (load_ok_s),
            .load_val (DIN[4*g +: 4]),
            .digit    (BCD[4*g +: 4]),
            .at_max   (at_max_s[g]),
            .at_min   (at_min_s[g])
        );
    end

    // Event pulse registers, aligned with the count update.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            wrap_r <= 1'b0;
            err_r  <= 1'b0;
        end else begin
            wrap_r <= edge_hit_s;
            err_r  <= LOAD & ~(&nib_ok_s);
        end
    end

    assign WRAP = wrap_r;
    assign ERR  = err_r;
    assign ZERO = below_min_s[DIGITS];

endmodule

// File: tb/tb_bcd_updown_counter.sv
// -----------------------------------------------------------------------------
// tb_bcd_updown_counter
// Self-checking bench for bcd_updown_counter (DIGITS = 4). The reference model
// keeps the count as a plain integer and converts it to BCD arithmetically.
// Honours BCD_CNT_SAT_EN when defined.
// -----------------------------------------------------------------------------
module tb_bcd_updown_counter;

    localparam int DIGITS = 4;
    localparam int W      = 4 * DIGITS;
    localparam int MAXV   = 9999;

    logic         CLK;
    logic         RST_N;
    logic         EN;
    logic         DIR;
    logic         LOAD;
    logic [W-1:0] DIN;
    logic [W-1:0] BCD;
    logic         WRAP;
    logic         ZERO;
    logic         ERR;

    int vectors_applied;
    int miscompares;

    // reference model state
    int   m_cnt;
    logic m_wrap;
    logic m_err;
    int   dut_wraps;
    int   mdl_wraps;

    bcd_updown_counter #(.DIGITS(DIGITS)) dut (
        .CLK   (CLK),
        .RST_N (RST_N),
        .EN    (EN),
        .DIR   (DIR),
        .LOAD  (LOAD),
        .DIN   (DIN),
        .BCD   (BCD),
        .WRAP  (WRAP),
        .ZERO  (ZERO),
        .ERR   (ERR)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    function automatic logic [W-1:0] to_bcd(input int v);
        logic [W-1:0] r;
        int           t;
        r = '0;
        t = v;
        for (int i = 0; i < DIGITS; i++) begin
            r[4*i +: 4] = 4'(t % 10);
            t = t / 10;
        end
        return r;
    endfunction

    function automatic bit bcd_ok(input logic [W-1:0] d);
        bit ok;
        ok = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (d[4*i +: 4] > 4'd9) ok = 1'b0;
        end
        return ok;
    endfunction

    function automatic int from_bcd(input logic [W-1:0] d);
        int v;
        v = 0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            v = v * 10 + int'(d[4*i +: 4]);
        end
        return v;
    endfunction

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors_applied++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_all(input string tag);
        check_val({tag, ".bcd"},  32'(BCD),  32'(to_bcd(m_cnt)));
        check_val({tag, ".wrap"}, 32'(WRAP), 32'(m_wrap));
        check_val({tag, ".err"},  32'(ERR),  32'(m_err));
        check_val({tag, ".zero"}, 32'(ZERO), 32'(m_cnt == 0));
    endtask

    // Behavioural reference for one clock edge.
    task automatic model_step(input logic en, input logic dir, input logic ld, input logic [W-1:0] din);
        m_wrap = 1'b0;
        m_err  = 1'b0;
        if (ld) begin
            if (bcd_ok(din)) m_cnt = from_bcd(din);
            else             m_err = 1'b1;
        end else if (en) begin
            if (dir) begin
                if (m_cnt == MAXV) begin
                    m_wrap = 1'b1;
`ifdef BCD_CNT_SAT_EN
                    m_cnt = MAXV;
`else
                    m_cnt = 0;
`endif
                end else begin
                    m_cnt = m_cnt + 1;
                end
            end else begin
                if (m_cnt == 0) begin
                    m_wrap = 1'b1;
`ifdef BCD_CNT_SAT_EN
                    m_cnt = 0;
`else
                    m_cnt = MAXV;
`endif
                end else begin
                    m_cnt = m_cnt - 1;
                end
            end
        end
        if (m_wrap) mdl_wraps++;
    endtask

    // Drive one cycle, advance the model at the edge, sample 1 time unit later.
    task automatic cyc(input string tag, input logic en, input logic dir, input logic ld,
                       input logic [W-1:0] din, input bit chk);
        EN   = en;
        DIR  = dir;
        LOAD = ld;
        DIN  = din;
        @(posedge CLK);
        model_step(en, dir, ld, din);
        #1;
        if (WRAP) dut_wraps++;
        if (chk) check_all(tag);
    endtask

    task automatic do_reset(input string tag);
        #2;
        RST_N = 1'b0;
        #1;
        m_cnt  = 0;
        m_wrap = 1'b0;
        m_err  = 1'b0;
        check_all(tag);
        #2;
        RST_N = 1'b1;
    endtask

    initial begin
        vectors_applied = 0;
        miscompares     = 0;
        m_cnt = 0; m_wrap = 1'b0; m_err = 1'b0;
        dut_wraps = 0; mdl_wraps = 0;
        RST_N = 1'b0; EN = 1'b0; DIR = 1'b0; LOAD = 1'b0; DIN = '0;
        @(posedge CLK);
        #1;
        check_all("reset");
        #3;
        RST_N = 1'b1;
        @(posedge CLK);
        #1;
        check_all("post_reset_hold");

        // Up carry across the top boundary.
        cyc("ld9998",  1'b0, 1'b0, 1'b1, 16'h9998, 1'b1);
        cyc("up9999",  1'b1, 1'b1, 1'b0, 16'h0000, 1'b1);
        cyc("upwrap",  1'b1, 1'b1, 1'b0, 16'h0000, 1'b1);
        cyc("idle",    1'b0, 1'b1, 1'b0, 16'h0000, 1'b1);

        // Down borrow and bottom boundary.
        cyc("ld0010",  1'b0, 1'b0, 1'b1, 16'h0010, 1'b1);
        cyc("dn0009",  1'b1, 1'b0, 1'b0, 16'h0000, 1'b1);
        cyc("ld0000",  1'b0, 1'b0, 1'b1, 16'h0000, 1'b1);
        cyc("dnwrap",  1'b1, 1'b0, 1'b0, 16'h0000, 1'b1);
        cyc("dirflip", 1'b1, 1'b1, 1'b0, 16'h0000, 1'b1);

        // Invalid load keeps the count and pulses ERR.
        cyc("ld0042",  1'b0, 1'b0, 1'b1, 16'h0042, 1'b1);
        cyc("badld",   1'b1, 1'b1, 1'b1, 16'h003A, 1'b1);
        cyc("errdone", 1'b0, 1'b0, 1'b0, 16'h0000, 1'b1);
        cyc("badtop",  1'b0, 1'b0, 1'b1, 16'hF000, 1'b1);

        // LOAD wins over EN.
        cyc("prio",    1'b1, 1'b1, 1'b1, 16'h0055, 1'b1);
        cyc("prio_nx", 1'b1, 1'b1, 1'b0, 16'h0000, 1'b1);

        // Asynchronous reset mid-count at 37.
        cyc("ld0036",  1'b0, 1'b0, 1'b1, 16'h0036, 1'b1);
        cyc("up0037",  1'b1, 1'b1, 1'b0, 16'h0000, 1'b1);
        EN = 1'b1; DIR = 1'b1; LOAD = 1'b0;
        do_reset("async_rst37");

        // Reset cancels a pending WRAP pulse.
        cyc("ld9999",  1'b0, 1'b0, 1'b1, 16'h9999, 1'b1);
        cyc("wrapprd", 1'b1, 1'b1, 1'b0, 16'h0000, 1'b1);
        do_reset("async_rst_wrap");

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            logic         r_en, r_dir, r_ld;
            logic [W-1:0] r_din;
            r_en  = 1'($urandom_range(0, 3) != 0);
            r_dir = 1'($urandom_range(0, 1));
            r_ld  = 1'($urandom_range(0, 9) == 0);
            if ($urandom_range(0, 1) == 1) r_din = to_bcd(int'($urandom_range(0, MAXV)));
            else                           r_din = W'($urandom);
            // bias towards the boundaries now and then
            if ($urandom_range(0, 15) == 0) r_din = ($urandom_range(0, 1) == 1) ? 16'h9999 : 16'h0000;
            cyc("rand", r_en, r_dir, r_ld, r_din, 1'b1);
        end

        // Long run: 20000 up steps from zero.
        do_reset("long_rst");
        dut_wraps = 0;
        mdl_wraps = 0;
        for (int i = 0; i < 20000; i++) begin
            cyc("long", 1'b1, 1'b1, 1'b0, 16'h0000, 1'b1);
        end
        check_val("long_final", 32'(BCD), 32'(to_bcd(m_cnt)));
`ifndef BCD_CNT_SAT_EN
        check_val("long_final_zero", 32'(BCD), 32'h0000_0000);
`endif
        check_val("long_wraps", 32'(dut_wraps), 32'(mdl_wraps));

        $display("== %0d vectors applied, %0d miscompares ==", vectors_applied, miscompares);
        $finish;
    end

endmodule
